// File: rtl/lsu_split_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_split_access_ctrl
//  Description : Sequences LSU loads/stores onto a word-wide byte-enabled
//                memory, splitting word-crossing accesses and extending loads.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_split_access_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_wren,
    input  logic [2:0]        i_funct3,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic              o_mem_valid,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [3:0]        o_mem_byte_en,
    output logic              o_mem_wren,
    output logic [31:0]       o_mem_wdata,
    input  logic [31:0]       i_mem_rdata,
    output logic              o_ld_valid,
    output logic [31:0]       o_ld_data
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACC1   = 2'd1,
        S_ACC2   = 2'd2,
        S_RDWAIT = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic                r_wren;
    logic [2:0]          r_funct3;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic [31:0]         r_lo_buf;
    logic [ADDR_W-1:0]   r_mem_addr_hold;
    logic [31:0]         r_mem_wdata_hold;
    logic                r_ld_valid;
    logic [31:0]         r_ld_data;

    logic                w_accept;
    logic                w_legal;
    logic [3:0]          w_size_mask;
    logic [1:0]          w_off;
    logic [7:0]          w_mask8;
    logic [63:0]         w_wdata64;
    logic                w_split;
    logic [ADDR_W-1:0]   w_acc1_addr;
    logic [ADDR_W-1:0]   w_acc2_addr;
    logic [63:0]         w_rd64;
    logic [31:0]         w_rd_shift;
    logic [31:0]         w_ld_ext;

    logic                w_mem_valid;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic [3:0]          w_mem_be;
    logic                w_mem_wren;
    logic [31:0]         w_mem_wdata;

    // Illegal requests get an empty mask, so they never split and never write.
    always_comb begin
        w_legal     = 1'b0;
        w_size_mask = 4'b0000;
        case (r_funct3)
            3'b000: begin w_legal = 1'b1; w_size_mask = 4'b0001; end
            3'b001: begin w_legal = 1'b1; w_size_mask = 4'b0011; end
            3'b010: begin w_legal = 1'b1; w_size_mask = 4'b1111; end
            3'b100: begin w_legal = ~r_wren; w_size_mask = 4'b0001; end
            3'b101: begin w_legal = ~r_wren; w_size_mask = 4'b0011; end
            default: begin w_legal = 1'b0; w_size_mask = 4'b0000; end
        endcase
        if (!w_legal) begin
            w_size_mask = 4'b0000;
        end
    end

    assign w_off       = r_addr[1:0];
    assign w_mask8     = {4'b0000, w_size_mask} << w_off;
    assign w_wdata64   = {32'h0, r_wdata} << {w_off, 3'b000};
    assign w_split     = |w_mask8[7:4];
    assign w_acc1_addr = {r_addr[ADDR_W-1:2], 2'b00};
    assign w_acc2_addr = w_acc1_addr + ADDR_W'(4);

    // In RDWAIT the bus carries the last word read; lo_buf holds the first.
    assign w_rd64     = w_split ? {i_mem_rdata, r_lo_buf} : {32'h0, i_mem_rdata};
    assign w_rd_shift = 32'(w_rd64 >> {w_off, 3'b000});

    always_comb begin
        w_ld_ext = 32'h0;
        case (r_funct3)
            3'b000:  w_ld_ext = {{24{w_rd_shift[7]}}, w_rd_shift[7:0]};
            3'b001:  w_ld_ext = {{16{w_rd_shift[15]}}, w_rd_shift[15:0]};
            3'b010:  w_ld_ext = w_rd_shift;
            3'b100:  w_ld_ext = {24'h0, w_rd_shift[7:0]};
            3'b101:  w_ld_ext = {16'h0, w_rd_shift[15:0]};
            default: w_ld_ext = 32'h0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        o_req_ready  = 1'b0;
        w_accept     = 1'b0;
        w_mem_valid  = 1'b0;
        w_mem_wren   = 1'b0;
        w_mem_be     = 4'b0000;
        w_mem_addr   = r_mem_addr_hold;
        w_mem_wdata  = r_mem_wdata_hold;
        case (r_state)
            S_IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = S_ACC1;
                end
            end
            S_ACC1: begin
                w_mem_valid = 1'b1;
                w_mem_addr  = w_acc1_addr;
                w_mem_be    = w_mask8[3:0];
                w_mem_wdata = w_wdata64[31:0];
                w_mem_wren  = r_wren & w_legal;
                if (w_split) begin
                    w_next_state = S_ACC2;
                end else if (r_wren) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_RDWAIT;
                end
            end
            S_ACC2: begin
                w_mem_valid  = 1'b1;
                w_mem_addr   = w_acc2_addr;
                w_mem_be     = w_mask8[7:4];
                w_mem_wdata  = w_wdata64[63:32];
                w_mem_wren   = r_wren;
                w_next_state = r_wren ? S_IDLE : S_RDWAIT;
            end
            S_RDWAIT: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wren           <= 1'b0;
            r_funct3         <= 3'b000;
            r_addr           <= '0;
            r_wdata          <= 32'h0;
            r_lo_buf         <= 32'h0;
            r_mem_addr_hold  <= '0;
            r_mem_wdata_hold <= 32'h0;
            r_ld_valid       <= 1'b0;
            r_ld_data        <= 32'h0;
        end else begin
            r_mem_addr_hold  <= w_mem_addr;
            r_mem_wdata_hold <= w_mem_wdata;
            r_ld_valid       <= (r_state == S_RDWAIT);
            if (w_accept) begin
                r_wren   <= i_req_wren;
                r_funct3 <= i_funct3;
                r_addr   <= i_addr;
                r_wdata  <= i_wdata;
            end
            if (r_state == S_ACC2) begin
                r_lo_buf <= i_mem_rdata;
            end
            if (r_state == S_RDWAIT) begin
                r_ld_data <= w_ld_ext;
            end
        end
    end

    assign o_mem_valid   = w_mem_valid;
    assign o_mem_addr    = w_mem_addr;
    assign o_mem_byte_en = w_mem_be;
    assign o_mem_wren    = w_mem_wren;
    assign o_mem_wdata   = w_mem_wdata;
    assign o_ld_valid    = r_ld_valid;
    assign o_ld_data     = r_ld_data;

endmodule
`default_nettype wire
